// File: rtl/pulse_window_integrator.sv
// Pulse window integrator.
// On each rising edge of trig, waits a programmable number of cycles, then
// accumulates a programmable number of consecutive signed samples with
// saturating arithmetic. The result is presented with a one-cycle valid
// strobe. A trigger edge seen while a window is running is reported on
// trig_miss and otherwise ignored.
module pulse_window_integrator #(
  parameter int DIN_W = 16,
  parameter int SUM_W = 24,
  parameter int DLY_W = 8,
  parameter int LEN_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig,
  input  logic signed [DIN_W-1:0] din,
  input  logic [DLY_W-1:0]        delay,
  input  logic [LEN_W-1:0]        win_len,
  output logic signed [SUM_W-1:0] sum_out,
  output logic                    sum_valid,
  output logic                    sat,
  output logic                    busy,
  output logic                    trig_miss
);

  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_INTEG} state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic                    trig_a;
  logic                    trig_b;
  logic                    edge_det;

  logic [DLY_W-1:0]        dly_cnt;
  logic [LEN_W-1:0]        len_cnt;
  logic signed [SUM_W-1:0] acc;
  logic                    acc_sat;

  logic signed [SUM_W-1:0] din_ext;
  logic signed [SUM_W:0]   add_wide;
  logic signed [SUM_W-1:0] add_val;
  logic                    add_ovf;

  logic                    start;
  logic                    miss;
  logic                    finish;
  logic signed [SUM_W-1:0] res_val;
  logic                    res_sat;

  // The extra top bit of the wide sum disagrees with the sign bit exactly
  // when the SUM_W-bit signed add has overflowed.
  function automatic logic sum_overflow(input logic signed [SUM_W:0] v);
    return v[SUM_W] ^ v[SUM_W-1];
  endfunction

  // Clamp a one-bit-wider sum back into SUM_W bits, toward the true sign.
  function automatic logic signed [SUM_W-1:0] clamp_sum(input logic signed [SUM_W:0] v);
    if (sum_overflow(v)) begin
      return v[SUM_W] ? SUM_MIN : SUM_MAX;
    end
    return v[SUM_W-1:0];
  endfunction

  // Trigger history: two registered copies give the rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_a <= 1'b0;
      trig_b <= 1'b0;
    end else begin
      trig_a <= trig;
      trig_b <= trig_a;
    end
  end

  assign edge_det = trig_a & ~trig_b;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: zero delay skips DELAY, zero length skips INTEG.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (edge_det) begin
          if (delay != '0) begin
            state_nxt = ST_DELAY;
          end else if (win_len != '0) begin
            state_nxt = ST_INTEG;
          end
        end
      end
      ST_DELAY: begin
        if (dly_cnt <= DLY_W'(1)) begin
          state_nxt = (len_cnt != '0) ? ST_INTEG : ST_IDLE;
        end
      end
      ST_INTEG: begin
        if (len_cnt <= LEN_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode: window start, missed edge, and result completion.
  always_comb begin
    busy    = (state != ST_IDLE);
    start   = (state == ST_IDLE) && edge_det;
    miss    = (state != ST_IDLE) && edge_det;
    finish  = 1'b0;
    res_val = '0;
    res_sat = 1'b0;
    case (state)
      ST_IDLE: begin
        if (edge_det && (delay == '0) && (win_len == '0)) begin
          finish = 1'b1;
        end
      end
      ST_DELAY: begin
        if ((dly_cnt <= DLY_W'(1)) && (len_cnt == '0)) begin
          finish = 1'b1;
        end
      end
      ST_INTEG: begin
        if (len_cnt <= LEN_W'(1)) begin
          finish  = 1'b1;
          res_val = add_val;
          res_sat = acc_sat | add_ovf;
        end
      end
      default: finish = 1'b0;
    endcase
  end

  // Saturating accumulate of the sign-extended sample.
  always_comb begin
    din_ext  = SUM_W'(din);
    add_wide = (SUM_W+1)'(acc) + (SUM_W+1)'(din_ext);
    add_val  = clamp_sum(add_wide);
    add_ovf  = sum_overflow(add_wide);
  end

  // Window counters and accumulator; settings are captured only at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_cnt <= '0;
      len_cnt <= '0;
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (start) begin
      dly_cnt <= delay;
      len_cnt <= win_len;
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (state == ST_DELAY) begin
      dly_cnt <= dly_cnt - DLY_W'(1);
    end else if (state == ST_INTEG) begin
      acc     <= add_val;
      acc_sat <= acc_sat | add_ovf;
      len_cnt <= len_cnt - LEN_W'(1);
    end
  end

  // Registered result, strobes; sum_out and sat hold between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out   <= '0;
      sat       <= 1'b0;
      sum_valid <= 1'b0;
      trig_miss <= 1'b0;
    end else begin
      sum_valid <= finish;
      trig_miss <= miss;
      if (finish) begin
        sum_out <= res_val;
        sat     <= res_sat;
      end
    end
  end

endmodule
